fpmul_arbiter: RTL and testbench
================================

# fpmul_arbiter

Round-robin arbiter and sequencer that shares one multi-cycle `FPMul` unit between `NREQ` requesters. It accepts operand pairs over per-requester valid/ready handshakes and drives `Start`/`A`/`B` into `FPMul`, holding the operands stable for the whole operation. It captures `P` and the six status flags on `Done` and returns them to the originating requester as a one-cycle response pulse. It sits between the requesting pipeline stages and the shared multiplier, with a watchdog that guards against a hung unit.

## Interface
- `NREQ`, default 4: number of requesters, legal range 2..8.
- `TIMEOUT`, default 16: maximum WAIT cycles before a watchdog abort, legal range 10..255.

Ports:
- `clk` in 1: the single clock.
- `rst` in 1: reset, synchronous, active-high. The same `rst` also drives `FPMul.rst`.
- `req_valid` in NREQ: per-requester request valid.
- `req_a` in 32*NREQ: operand A; requester i uses bits [32i+31:32i].
- `req_b` in 32*NREQ: operand B, packed the same way as `req_a`.
- `req_ready` out NREQ: one-hot grant/accept.
- `rsp_valid` out NREQ: one-hot, one-cycle response pulse.
- `rsp_p` out 32: product.
- `rsp_flags` out 6: {OF, UF, NanF, InfF, DNF, ZF}.
- `rsp_timeout` out 1: asserted with `rsp_valid` when the watchdog aborted the operation.
- `busy` out 1: high in every state except IDLE.
- `mul_start` out 1: to `FPMul.Start`.
- `mul_a` out 32: to `FPMul.A`.
- `mul_b` out 32: to `FPMul.B`.
- `mul_done` in 1: from `FPMul.Done`.
- `mul_p` in 32: from `FPMul.P`.
- `mul_flags` in 6: from {OF, UF, NanF, InfF, DNF, ZF}.

## Operation
- States and transitions:
  - IDLE → ISSUE when any `req_valid` is high.
  - ISSUE → WAIT unconditionally.
  - WAIT → RESP on `mul_done`, or when the watchdog count reaches `TIMEOUT`.
  - RESP → IDLE unconditionally.
- Arbitration:
  - Round-robin. The search starts at `last+1` mod NREQ and the first valid index wins.
  - `last` updates to the winner on accept.
  - Reset value of `last` is NREQ-1, so requester 0 has first priority.
- Handshake:
  - `req_ready[i] = (state==IDLE) && grant[i]`, combinational from `req_valid`.
  - Accept occurs on `req_valid[i] && req_ready[i]`. At most one accept per operation.
  - On accept, `req_a[i]`/`req_b[i]` are registered into the operand regs and `i` into the owner reg.
  - Requesters hold valid and operands until ready. Dropping `req_valid` before ready is legal and simply withdraws the request.
- Operand and start control:
  - `mul_a`/`mul_b` are driven from the operand regs and stay stable from ISSUE through RESP.
  - `mul_start` is high only in ISSUE, for exactly one cycle.
- WAIT and capture:
  - The watchdog counter clears in ISSUE and increments in each WAIT cycle.
  - On `mul_done` in WAIT: `mul_p` and `mul_flags` are registered into the response regs and `rsp_timeout` is cleared.
  - On watchdog expiry: `rsp_p=32'h7FC00000`, `rsp_flags=6'b001000` (NanF only), `rsp_timeout=1`.
- Response:
  - In RESP, `rsp_valid[owner]=1`.
  - `rsp_p`, `rsp_flags` and `rsp_timeout` hold their value until the next capture.
- `mul_done` outside WAIT is ignored; this covers a late Done arriving after a timeout.
- Reset (any cycle, including mid-operation):
  - state=IDLE, `last`=NREQ-1.
  - `mul_start=0`, `rsp_valid=0`, `req_ready` gated low by state for that cycle.
  - `rsp_p=0`, `rsp_flags=0`, `rsp_timeout=0`, operand regs=0, `busy=0`.
  - The in-flight operation is discarded; no response is issued.

## Timing
- Accept occurs at cycle 0 (IDLE) and `mul_start` at cycle 1; `FPMul` loads in its wait-for-start state.
- Normal path:
  - `mul_done` arrives at cycle 9 and `rsp_valid` at cycle 10.
  - The next accept is possible at cycle 11, with its start at cycle 12.
  - The multiplier passes through its reset state at cycle 10 and is back in its wait-for-start state by cycle 11, so a start is never lost.
- Special operands (NaN/Inf/zero early exit): `mul_done` at cycle 6, `rsp_valid` at cycle 7.
- Watchdog: without a `mul_done`, `rsp_valid` with `rsp_timeout` occurs at cycle `TIMEOUT+2`.
- After `rst` deasserts, the earliest `mul_start` is cycle 1, which is after the multiplier leaves its reset state.
- Maximum throughput is one operation per 11 cycles on the normal path.

## Test plan
- Single request: `req_a[0]`=0x40000000, `req_b[0]`=0x40400000 → `rsp_valid[0]` 10 cycles after accept, `rsp_p`=0x40C00000, `rsp_flags`=0, `rsp_timeout`=0.
- Rounding: requester 2 sends 0x3FC00000 × 0x3FC00000 → `rsp_valid[2]`, `rsp_p`=0x40100000; `mul_a`/`mul_b` are stable from start through response.
- Special case: 0x7F800000 × 0x00000000 → response 7 cycles after accept with NanF=1.
- Fairness: all four `req_valid` held high → grant order 0,1,2,3,0,1, with responses 11 cycles apart; each `rsp_valid` goes to the matching index.
- Watchdog: `FPMul` replaced by a stub whose Done never fires → `rsp_valid` at cycle 18, `rsp_p`=0x7FC00000, `rsp_timeout`=1; a stray `mul_done` injected afterwards is ignored.
- Reset mid-WAIT: `rst` pulsed at cycle 5 → no `rsp_valid`, `busy`=0 next cycle; a new request is granted to requester 0 first.

Source files
------------

// File: rtl/fpmul_arbiter.sv
// fpmul_arbiter: round-robin arbiter that shares one multi-cycle FPMul between NREQ requesters,
// holding operands across the operation and returning result/flags as a one-cycle pulse.
module fpmul_arbiter #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [32*NREQ-1:0]   req_a,
    input  logic [32*NREQ-1:0]   req_b,
    output logic [NREQ-1:0]      req_ready,
    output logic [NREQ-1:0]      rsp_valid,
    output logic [31:0]          rsp_p,
    output logic [5:0]           rsp_flags,
    output logic                 rsp_timeout,
    output logic                 busy,
    output logic                 mul_start,
    output logic [31:0]          mul_a,
    output logic [31:0]          mul_b,
    input  logic                 mul_done,
    input  logic [31:0]          mul_p,
    input  logic [5:0]           mul_flags
);
    localparam int IW = $clog2(NREQ);
    localparam logic [NREQ-1:0] ONE = 1;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    state_t          r_state, w_next;
    logic [IW-1:0]   r_last, r_owner, w_win;
    logic            w_found, w_accept, w_expire;
    logic [31:0]     r_a, r_b, r_p;
    logic [5:0]      r_flags;
    logic            r_to;
    logic [7:0]      r_wd;

    // Search begins just after the last winner so every requester is reached within NREQ grants.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        for (int k = 1; k <= NREQ; k++) begin
            int j;
            j = (int'(r_last) + k) % NREQ;
            if (!w_found && req_valid[j]) begin
                w_found = 1'b1;
                w_win   = IW'(j);
            end
        end
    end

    assign w_accept  = (r_state == S_IDLE) && w_found;
    assign w_expire  = (r_wd == 8'(TIMEOUT - 1));
    assign req_ready = w_accept ? (ONE << w_win) : '0;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  w_next = w_found ? S_ISSUE : S_IDLE;
            S_ISSUE: w_next = S_WAIT;
            S_WAIT:  w_next = (mul_done || w_expire) ? S_RESP : S_WAIT;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_last  <= IW'(NREQ - 1);
            r_owner <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_wd    <= '0;
            r_p     <= '0;
            r_flags <= '0;
            r_to    <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_last  <= w_win;
                r_owner <= w_win;
                r_a     <= req_a[32*int'(w_win) +: 32];
                r_b     <= req_b[32*int'(w_win) +: 32];
            end
            if (r_state == S_ISSUE)
                r_wd <= '0;
            if (r_state == S_WAIT) begin
                r_wd <= r_wd + 8'd1;
                // A real Done wins over a simultaneous watchdog expiry.
                if (mul_done) begin
                    r_p     <= mul_p;
                    r_flags <= mul_flags;
                    r_to    <= 1'b0;
                end else if (w_expire) begin
                    r_p     <= 32'h7FC00000;
                    r_flags <= 6'b001000;
                    r_to    <= 1'b1;
                end
            end
        end
    end

    assign mul_start   = (r_state == S_ISSUE);
    assign mul_a       = r_a;
    assign mul_b       = r_b;
    assign busy        = (r_state != S_IDLE);
    assign rsp_valid   = (r_state == S_RESP) ? (ONE << r_owner) : '0;
    assign rsp_p       = r_p;
    assign rsp_flags   = r_flags;
    assign rsp_timeout = r_to;
endmodule

// File: tb/tb_fpmul_arbiter.sv
// tb_fpmul_arbiter: drives requesters and a behavioural FPMul stub, comparing every cycle
// against a timeline model of grants, latencies and held responses.
module tb_fpmul_arbiter;
    localparam int NREQ    = 4;
    localparam int TIMEOUT = 16;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic [NREQ-1:0]     req_valid = '0;
    logic [32*NREQ-1:0]  req_a = '0, req_b = '0;
    logic [NREQ-1:0]     req_ready, rsp_valid;
    logic [31:0]         rsp_p, mul_a, mul_b;
    logic [5:0]          rsp_flags;
    logic                rsp_timeout, busy, mul_start;
    logic                mul_done = 1'b0;
    logic [31:0]         mul_p = '0;
    logic [5:0]          mul_flags = '0;

    fpmul_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_p(rsp_p), .rsp_flags(rsp_flags),
        .rsp_timeout(rsp_timeout), .busy(busy), .mul_start(mul_start), .mul_a(mul_a),
        .mul_b(mul_b), .mul_done(mul_done), .mul_p(mul_p), .mul_flags(mul_flags)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_fail = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, c);
        end
    endtask

    int          c = 0;
    bit          pend [NREQ];
    logic [31:0] op_a [NREQ], op_b [NREQ];
    int          m_last, m_acc, m_rsp, m_free, m_owner, acc_w = -1;
    logic [31:0] m_a, m_b, e_p, h_p;
    logic [5:0]  e_f, h_f;
    logic        e_to, h_to;
    bit          gen_en = 0, refill = 0, hang = 0, rst_hold = 1;
    int          rst_cycle = -1, stray_cycle = -1, done_cycle = -1;
    logic [31:0] s_p = '0;
    logic [5:0]  s_f = '0;
    int          grants [$];

    function automatic bit special(input logic [31:0] x);
        return (x[30:23] == 8'hFF) || (x[30:0] == 31'd0);
    endfunction

    // Stub product/flag function; known test vectors return true IEEE results.
    function automatic logic [37:0] fref(input logic [31:0] a, input logic [31:0] b);
        if (a == 32'h40000000 && b == 32'h40400000) return {6'd0, 32'h40C00000};
        if (a == 32'h3FC00000 && b == 32'h3FC00000) return {6'd0, 32'h40100000};
        if (a == 32'h7F800000 && b == 32'h00000000) return {6'b001000, 32'h7FC00000};
        return {a[5:0] ^ b[31:26], a ^ {b[15:0], b[31:16]}};
    endfunction

    function automatic logic [31:0] rnd_op();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 7))
            0: r = 32'h7F800000;
            1: r = 32'h00000000;
            2: r = {r[31], 8'hFF, r[22:0]};
            default: ;
        endcase
        return r;
    endfunction

    function automatic int oh2i(input logic [NREQ-1:0] v);
        for (int i = 0; i < NREQ; i++) if (v[i]) return i;
        return -1;
    endfunction

    task automatic post(input int i, input logic [31:0] a, input logic [31:0] b);
        pend[i] = 1; op_a[i] = a; op_b[i] = b;
    endtask

    task automatic model_reset();
        m_last = NREQ - 1; m_acc = -100; m_rsp = -100; m_free = c + 1;
        h_p = '0; h_f = '0; h_to = 1'b0; done_cycle = -1; acc_w = -1;
    endtask

    task automatic step();
        logic [NREQ-1:0] exp_ready;
        @(posedge clk);
        c++;
        #1;
        if (acc_w >= 0) begin
            pend[acc_w] = 0;
            if (refill) post(acc_w, rnd_op(), rnd_op());
            acc_w = -1;
        end
        if (gen_en)
            for (int i = 0; i < NREQ; i++)
                if (!pend[i] && $urandom_range(0, 5) == 0) post(i, rnd_op(), rnd_op());
                else if (pend[i] && $urandom_range(0, 31) == 0) pend[i] = 0;
        rst       = rst_hold || (c == rst_cycle);
        mul_done  = (c == done_cycle) || (c == stray_cycle);
        mul_p     = (c == stray_cycle) ? $urandom : s_p;
        mul_flags = (c == stray_cycle) ? 6'h3F : s_f;
        for (int i = 0; i < NREQ; i++) begin
            req_valid[i]        = pend[i];
            req_a[32*i +: 32]   = op_a[i];
            req_b[32*i +: 32]   = op_b[i];
        end
        @(negedge clk);
        if (rst) begin
            model_reset();
        end else begin
            if (mul_start && !hang) begin
                done_cycle = c + ((special(mul_a) || special(mul_b)) ? 5 : 8);
                {s_f, s_p} = fref(mul_a, mul_b);
            end
            exp_ready = '0;
            if (c >= m_free)
                for (int k = 1; k <= NREQ; k++) begin
                    int j;
                    j = (m_last + k) % NREQ;
                    if (pend[j] && exp_ready == '0) begin
                        exp_ready[j] = 1'b1;
                        m_acc = c; m_owner = j; m_last = j; acc_w = j;
                        m_a = op_a[j]; m_b = op_b[j];
                        m_rsp = c + (hang ? TIMEOUT + 2 : ((special(m_a) || special(m_b)) ? 7 : 10));
                        m_free = m_rsp + 1;
                        {e_f, e_p} = hang ? {6'b001000, 32'h7FC00000} : fref(m_a, m_b);
                        e_to = hang;
                    end
                end
            check("req_ready", req_ready, exp_ready);
            if (req_ready != '0) grants.push_back(oh2i(req_ready));
            check("busy", busy, c > m_acc && c <= m_rsp);
            check("mul_start", mul_start, c == m_acc + 1);
            if (c > m_acc && c <= m_rsp) begin
                check("mul_a", mul_a, m_a);
                check("mul_b", mul_b, m_b);
            end
            if (c == m_rsp) begin
                h_p = e_p; h_f = e_f; h_to = e_to;
                check("rsp_valid", rsp_valid, 1 << m_owner);
            end else begin
                check("rsp_valid", rsp_valid, 0);
            end
            check("rsp_p", rsp_p, h_p);
            check("rsp_flags", rsp_flags, h_f);
            check("rsp_timeout", rsp_timeout, h_to);
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic drain();
        int n;
        bit any;
        gen_en = 0; refill = 0; n = 0;
        do begin
            step();
            n++;
            any = 0;
            for (int i = 0; i < NREQ; i++) any |= pend[i];
        end while ((any || c < m_free) && n < 300);
        if (n >= 300) check("drain_bound", 1, 0);
    endtask

    task automatic do_reset();
        rst_hold = 1; run(3);
        check("rst_busy", busy, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_p", rsp_p, 0);
        check("rst_rsp_flags", rsp_flags, 0);
        check("rst_rsp_timeout", rsp_timeout, 0);
        check("rst_mul_start", mul_start, 0);
        check("rst_mul_a", mul_a, 0);
        check("rst_mul_b", mul_b, 0);
        rst_hold = 0;
    endtask

    initial begin
        int c0;
        for (int i = 0; i < NREQ; i++) begin pend[i] = 0; op_a[i] = '0; op_b[i] = '0; end
        model_reset();
        do_reset();

        post(0, 32'h40000000, 32'h40400000); drain();
        check("single_p", rsp_p, 32'h40C00000);
        check("single_flags", rsp_flags, 0);
        post(2, 32'h3FC00000, 32'h3FC00000); drain();
        check("round_p", rsp_p, 32'h40100000);
        post(1, 32'h7F800000, 32'h00000000); drain();
        check("special_flags", rsp_flags, 6'b001000);

        do_reset();
        grants.delete();
        for (int i = 0; i < NREQ; i++) post(i, rnd_op(), rnd_op());
        refill = 1; run(6 * 11 + 2); drain();
        check("fair_count", grants.size() >= 6, 1);
        for (int k = 0; k < 6 && k < grants.size(); k++) check($sformatf("fair_grant%0d", k), grants[k], k % NREQ);

        gen_en = 1; run(400); drain();

        hang = 1; post(3, rnd_op(), rnd_op()); drain();
        check("wd_p", rsp_p, 32'h7FC00000);
        check("wd_timeout", rsp_timeout, 1);
        stray_cycle = c + 2; run(6); hang = 0;
        check("stray_timeout", rsp_timeout, 1);

        post(1, 32'h40000000, 32'h40400000); step();
        c0 = c;
        rst_cycle = c0 + 5; run(5);
        step();
        check("midrst_busy", busy, 0);
        grants.delete();
        post(2, rnd_op(), rnd_op()); post(0, rnd_op(), rnd_op());
        run(12);
        check("midrst_first_grant", grants.size() > 0 ? grants[0] : -1, 0);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
